sev_seg_scanner: RTL and testbench
==================================

# sev_seg_scanner

Parametrised N-digit multiplexed seven-segment driver, the next generation of our 4-digit display path. It combines glyph decoding, digit scanning, frame-synchronous input capture, PWM brightness and per-digit blink in one block. It sits between application registers (hex/letter codes) and the board's common-anode display pins (active-low anodes and segments).

## Interface
- N_DIGITS, 4: digit count, 1..8.
- DIV_BITS, 16: each digit slot lasts 2^DIV_BITS clocks.
- PWM_BITS, 3: brightness resolution, 1..DIV_BITS.
- BLINK_FRAMES, 64: frames per blink half-period, ≥1.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-low.
- digits_i  in  4*N_DIGITS  digit k code = digits_i[4k+3:4k]; digit 0 is rightmost.
- ltr_i  in  N_DIGITS  per-digit glyph mode: 0 = hex, 1 = letter.
- dp_i  in  N_DIGITS  per-digit decimal point, 1 = lit.
- blank_i  in  N_DIGITS  per-digit force-off.
- blink_i  in  N_DIGITS  per-digit blink enable.
- bright_i  in  PWM_BITS  brightness level; 0 = dark, all-ones = full on.
- an_o  out  N_DIGITS  anode enables, active-low, one-hot-low or all-high.
- sseg_o  out  8  segments, active-low; bit7 = dp, bits6..0 = g..a.

## Operation
- **Slot counter** `slot` (DIV_BITS wide) increments every clock and wraps to 0.
  - On wrap, digit index `idx` advances 0→N_DIGITS-1, then back to 0.
  - A frame is N_DIGITS slots.
- **Snapshot registers** hold digits_i, ltr_i, dp_i, blank_i, blink_i and bright_i.
  - They load while rst is low.
  - They also load on the edge where idx = N_DIGITS-1 and slot = all-ones, i.e. the last cycle of each frame.
  - Inputs changing mid-frame have no visible effect until the next frame. This gives tear-free display.
- **Frame counter** counts completed frames 0..BLINK_FRAMES-1.
  - On wrap it toggles `blink_phase`. Reset value of `blink_phase` is 0.
  - The phase is applied from the first slot of the new frame.
- **Hex glyphs** (code 0..F): standard 0-9, A, b, C, d, E, F. Examples: 0 → 0x40 in bits6..0; A → 0x08.
- **Letter glyphs** (codes 0..F): -, A, b, C, d, E, F, H, I, J, L, n, o, P, r, U. Code 0 ('-') lights g only, giving bits6..0 = 0x3F.
- **Digit active**: digit idx is active iff all of the following hold:
  - !blank[idx]
  - !(blink[idx] && blink_phase)
  - PWM on, where PWM on = (bright == all-ones) || (slot[DIV_BITS-1 -: PWM_BITS] < bright).
- **Outputs while the digit is active**:
  - an_o = ~(1 << idx).
  - sseg_o = {~dp[idx], glyph}.
- **Outputs while the digit is inactive**: an_o = all-ones and sseg_o = 0xFF. There is no ghosting.

## Timing
- **Reset**: while rst is low at a clk edge:
  - slot = 0, idx = 0, frame counter = 0, blink_phase = 0.
  - an_o = all-ones, sseg_o = 0xFF.
- **Output registers**: an_o and sseg_o are registered.
  - The value after edge e is computed from the counters and snapshot as they stood before edge e.
  - Latency is 1 clock from counter state to pins.
  - The first edge with rst high drives digit 0 from the snapshot captured during reset.
- **Digit k slot**: after reset release, digit k is driven after edges k·2^DIV_BITS+1 through (k+1)·2^DIV_BITS, relative to the first high edge counted as edge 1.
- **Blanking**: no additional blanking cycle is inserted between digits. an_o changes on exactly the edge on which sseg_o changes.
- **Simultaneous events**: a frame wrap coincident with a blink toggle and a snapshot load all take effect for the next frame's slot 0.
- **Mid-operation reset**: a reset asserted mid-operation blanks the outputs at the next edge, and scanning restarts from digit 0.
- **N_DIGITS = 1**: idx is fixed at 0, and the snapshot loads whenever slot = all-ones.

## Test plan
All scenarios use N_DIGITS=4, DIV_BITS=4, PWM_BITS=2 and BLINK_FRAMES=2.

1. **Reset and first scan.** Set digits_i=0x3210, ltr_i=0, dp_i=0, blank_i=0, bright_i=3, hold rst low 3 clocks, then release.
   - Edges 1-16: an_o=1110, sseg_o=0xC0.
   - Edges 17-32: an_o=1101, sseg_o=0xF9.
   - Wraps back to digit 0 after edge 64.
2. **Letter mode and decimal point.** Set digit 1 code 1 with ltr_i[1]=1 and dp_i[1]=1 → sseg_o=0x08 while an_o=1101.
   - Same code with ltr_i=0 → 0x79.
3. **Frame-synchronous capture.** Change digits_i from 0x3210 to 0x7777 during digit 2's slot.
   - Digits 2 and 3 still show 2 and 3.
   - The next frame shows 7 on all digits.
4. **PWM.** bright_i=1 → each digit is driven for 4 of its 16 slot cycles, cycles 0-3, with all-high anodes otherwise.
   - bright_i=0 → an_o stays 1111 indefinitely.
5. **Blink and blank.** blink_i=0001 → digit 0 is dark in frames 2-3 and lit in frames 0-1 and 4-5.
   - blank_i=0100 → digit 2 is never driven.
6. **Reset mid-frame.** Pull rst low during digit 2 → next edge gives an_o=1111 and sseg_o=0xFF.
   - After release, scanning restarts at digit 0 at edge 1.

Source files
------------

// File: rtl/sev_seg_scanner_if.sv
// ============================================================================
// sev_seg_scanner_if : register-side and pin-side signals of the scanner
// Rev 1.0
// ============================================================================
`default_nettype none

interface sev_seg_scanner_if #(
  parameter int N_DIGITS = 4,
  parameter int PWM_BITS = 3
);
  logic [4*N_DIGITS-1:0] digits_i;
  logic [N_DIGITS-1:0]   ltr_i;
  logic [N_DIGITS-1:0]   dp_i;
  logic [N_DIGITS-1:0]   blank_i;
  logic [N_DIGITS-1:0]   blink_i;
  logic [PWM_BITS-1:0]   bright_i;
  logic [N_DIGITS-1:0]   an_o;
  logic [7:0]            sseg_o;

  modport master (
    output digits_i, ltr_i, dp_i, blank_i, blink_i, bright_i,
    input  an_o, sseg_o
  );

  modport slave (
    input  digits_i, ltr_i, dp_i, blank_i, blink_i, bright_i,
    output an_o, sseg_o
  );
endinterface

`default_nettype wire

// File: rtl/sev_seg_scanner.sv
// ============================================================================
// sev_seg_scanner : N-digit multiplexed 7-seg driver, PWM dimming and blink
// Rev 1.0
// ============================================================================
`default_nettype none

module sev_seg_scanner #(
  parameter int N_DIGITS     = 4,
  parameter int DIV_BITS     = 16,
  parameter int PWM_BITS     = 3,
  parameter int BLINK_FRAMES = 64
) (
  input  wire logic        clk,
  input  wire logic        rst,
  sev_seg_scanner_if.slave bus
);
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(N_DIGITS - 1);
  localparam logic [FRM_W-1:0] C_FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

  logic [DIV_BITS-1:0]   r_slot;
  logic [IDX_W-1:0]      r_idx;
  logic [FRM_W-1:0]      r_frame;
  logic                  r_blink_phase;
  logic [4*N_DIGITS-1:0] r_digits;
  logic [N_DIGITS-1:0]   r_ltr;
  logic [N_DIGITS-1:0]   r_dp;
  logic [N_DIGITS-1:0]   r_blank;
  logic [N_DIGITS-1:0]   r_blink;
  logic [PWM_BITS-1:0]   r_bright;
  logic [N_DIGITS-1:0]   r_an;
  logic [7:0]            r_sseg;

  logic                  w_slot_wrap;
  logic                  w_frame_end;
  logic [3:0]            w_code;
  logic [6:0]            w_glyph;
  logic                  w_pwm_on;
  logic                  w_active;

  assign w_slot_wrap = &r_slot;
  assign w_frame_end = w_slot_wrap && (r_idx == C_IDX_LAST);
  assign w_code      = r_digits[{r_idx, 2'b00} +: 4];
  assign w_pwm_on    = (&r_bright) || (r_slot[DIV_BITS-1 -: PWM_BITS] < r_bright);
  assign w_active    = !r_blank[r_idx] && !(r_blink[r_idx] && r_blink_phase) && w_pwm_on;

  // Active-low glyph patterns, bit order g..a
  always_comb begin
    w_glyph = 7'h7F;
    if (r_ltr[r_idx]) begin
      case (w_code)
        4'h0: w_glyph = 7'h3F;  4'h1: w_glyph = 7'h08;
        4'h2: w_glyph = 7'h03;  4'h3: w_glyph = 7'h46;
        4'h4: w_glyph = 7'h21;  4'h5: w_glyph = 7'h06;
        4'h6: w_glyph = 7'h0E;  4'h7: w_glyph = 7'h09;
        4'h8: w_glyph = 7'h79;  4'h9: w_glyph = 7'h61;
        4'hA: w_glyph = 7'h47;  4'hB: w_glyph = 7'h2B;
        4'hC: w_glyph = 7'h23;  4'hD: w_glyph = 7'h0C;
        4'hE: w_glyph = 7'h2F;  4'hF: w_glyph = 7'h41;
        default: w_glyph = 7'h7F;
      endcase
    end else begin
      case (w_code)
        4'h0: w_glyph = 7'h40;  4'h1: w_glyph = 7'h79;
        4'h2: w_glyph = 7'h24;  4'h3: w_glyph = 7'h30;
        4'h4: w_glyph = 7'h19;  4'h5: w_glyph = 7'h12;
        4'h6: w_glyph = 7'h02;  4'h7: w_glyph = 7'h78;
        4'h8: w_glyph = 7'h00;  4'h9: w_glyph = 7'h10;
        4'hA: w_glyph = 7'h08;  4'hB: w_glyph = 7'h03;
        4'hC: w_glyph = 7'h46;  4'hD: w_glyph = 7'h21;
        4'hE: w_glyph = 7'h06;  4'hF: w_glyph = 7'h0E;
        default: w_glyph = 7'h7F;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_slot        <= '0;
      r_idx         <= '0;
      r_frame       <= '0;
      r_blink_phase <= 1'b0;
      r_an          <= '1;
      r_sseg        <= 8'hFF;
    end else begin
      r_slot <= r_slot + DIV_BITS'(1);
      if (w_slot_wrap)
        r_idx <= w_frame_end ? '0 : r_idx + IDX_W'(1);
      if (w_frame_end) begin
        if (r_frame == C_FRM_LAST) begin
          r_frame       <= '0;
          r_blink_phase <= ~r_blink_phase;
        end else begin
          r_frame <= r_frame + FRM_W'(1);
        end
      end
      r_an   <= w_active ? ~(N_DIGITS'(1) << r_idx) : '1;
      r_sseg <= w_active ? {~r_dp[r_idx], w_glyph} : 8'hFF;
    end
  end

  // Snapshot loads during reset and on the last cycle of each frame only,
  // so a frame is always drawn from one coherent set of inputs.
  always_ff @(posedge clk) begin
    if (!rst || w_frame_end) begin
      r_digits <= bus.digits_i;
      r_ltr    <= bus.ltr_i;
      r_dp     <= bus.dp_i;
      r_blank  <= bus.blank_i;
      r_blink  <= bus.blink_i;
      r_bright <= bus.bright_i;
    end
  end

  assign bus.an_o   = r_an;
  assign bus.sseg_o = r_sseg;
endmodule

`default_nettype wire

// File: tb/tb_sev_seg_scanner.sv
// ============================================================================
// tb_sev_seg_scanner : directed scenarios plus random traffic vs. a cycle model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_sev_seg_scanner;
  localparam int N     = 4;
  localparam int D     = 4;
  localparam int P     = 2;
  localparam int B     = 2;
  localparam int SLOT  = 1 << D;
  localparam int FRAME = N * SLOT;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  sev_seg_scanner_if #(.N_DIGITS(N), .PWM_BITS(P)) bus ();

  sev_seg_scanner #(
    .N_DIGITS(N), .DIV_BITS(D), .PWM_BITS(P), .BLINK_FRAMES(B)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  // Glyphs described by their lit segment letters
  string hex_tab [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                          "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};
  string ltr_tab [16] = '{"g", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg", "bcefg",
                          "bc", "bcde", "def", "ceg", "cdeg", "abefg", "eg", "bcdef"};

  function automatic logic [6:0] seg_of(string s);
    logic [6:0] r = 7'h7F;
    for (int i = 0; i < s.len(); i++) begin
      int k = int'(s[i]) - 97;
      r[k] = 1'b0;
    end
    return r;
  endfunction

  // Reference model state: cycles since reset release and the frame snapshot
  int          t;
  logic [15:0] s_dig;
  logic [3:0]  s_ltr, s_dp, s_blank, s_blink;
  logic [1:0]  s_br;
  logic [3:0]  exp_an;
  logic [7:0]  exp_sseg;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
    end
  endtask

  task automatic model_step();
    if (!rst) begin
      exp_an = 4'hF; exp_sseg = 8'hFF; t = 0;
      s_dig = bus.digits_i; s_ltr = bus.ltr_i; s_dp = bus.dp_i;
      s_blank = bus.blank_i; s_blink = bus.blink_i; s_br = bus.bright_i;
    end else begin
      int slot = t % SLOT;
      int idx  = (t / SLOT) % N;
      int fr   = t / FRAME;
      bit phase = ((fr / B) % 2) == 1;
      bit on = (s_br == 2'd3) || ((slot >> (D - P)) < int'(s_br));
      bit act = !s_blank[idx] && !(s_blink[idx] && phase) && on;
      if (act) begin
        int code = int'(s_dig[idx*4 +: 4]);
        exp_an = 4'hF & ~(4'd1 << idx);
        exp_sseg = {~s_dp[idx], seg_of(s_ltr[idx] ? ltr_tab[code] : hex_tab[code])};
      end else begin
        exp_an = 4'hF; exp_sseg = 8'hFF;
      end
      if (slot == SLOT - 1 && idx == N - 1) begin
        s_dig = bus.digits_i; s_ltr = bus.ltr_i; s_dp = bus.dp_i;
        s_blank = bus.blank_i; s_blink = bus.blink_i; s_br = bus.bright_i;
      end
      t++;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    chk("model_an", 32'(bus.an_o), 32'(exp_an));
    chk("model_sseg", 32'(bus.sseg_o), 32'(exp_sseg));
  endtask

  task automatic set_in(input logic [15:0] dg, input logic [3:0] lt, input logic [3:0] dp,
                        input logic [3:0] bl, input logic [3:0] bk, input logic [1:0] br);
    bus.digits_i = dg; bus.ltr_i = lt; bus.dp_i = dp;
    bus.blank_i = bl; bus.blink_i = bk; bus.bright_i = br;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    repeat (n) tick();
    chk("reset_an", 32'(bus.an_o), 32'hF);
    chk("reset_sseg", 32'(bus.sseg_o), 32'hFF);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    set_in(16'h3210, 4'h0, 4'h0, 4'h0, 4'h0, 2'd3);
    @(negedge clk);

    // Reset, first scan, frame-synchronous capture
    do_reset(3);
    tick();
    chk("scan_e1_an", 32'(bus.an_o), 32'b1110);
    chk("scan_e1_sseg", 32'(bus.sseg_o), 32'hC0);
    repeat (16) tick();
    chk("scan_e17_an", 32'(bus.an_o), 32'b1101);
    chk("scan_e17_sseg", 32'(bus.sseg_o), 32'hF9);
    repeat (18) tick();
    bus.digits_i = 16'h7777;
    repeat (5) tick();
    chk("tear_e40_sseg", 32'(bus.sseg_o), 32'hA4);
    repeat (9) tick();
    chk("tear_e49_an", 32'(bus.an_o), 32'b0111);
    chk("tear_e49_sseg", 32'(bus.sseg_o), 32'hB0);
    repeat (16) tick();
    chk("wrap_e65_an", 32'(bus.an_o), 32'b1110);
    chk("new_frame_sseg", 32'(bus.sseg_o), 32'hF8);

    // Mid-frame reset during digit 2, then restart at digit 0
    repeat (40) tick();
    rst = 1'b0;
    tick();
    chk("midrst_an", 32'(bus.an_o), 32'hF);
    chk("midrst_sseg", 32'(bus.sseg_o), 32'hFF);
    rst = 1'b1;
    tick();
    chk("restart_an", 32'(bus.an_o), 32'b1110);

    // Letter mode with decimal point, then hex for the same code
    set_in(16'h0010, 4'b0010, 4'b0010, 4'h0, 4'h0, 2'd3);
    do_reset(2);
    repeat (17) tick();
    chk("ltr_an", 32'(bus.an_o), 32'b1101);
    chk("ltr_sseg", 32'(bus.sseg_o), 32'h08);
    bus.ltr_i = 4'h0;
    repeat (64) tick();
    chk("hex_dp_sseg", 32'(bus.sseg_o), 32'h79);

    // PWM at level 1: lit for slot cycles 0..3 only
    set_in(16'h3210, 4'h0, 4'h0, 4'h0, 4'h0, 2'd1);
    do_reset(2);
    repeat (4) tick();
    chk("pwm_on_an", 32'(bus.an_o), 32'b1110);
    tick();
    chk("pwm_off_an", 32'(bus.an_o), 32'hF);

    // Blink on digit 0, blank on digit 2
    set_in(16'h3210, 4'h0, 4'h0, 4'b0100, 4'b0001, 2'd3);
    do_reset(2);
    repeat (129) tick();
    chk("blink_dark_an", 32'(bus.an_o), 32'hF);
    repeat (128) tick();
    chk("blink_lit_an", 32'(bus.an_o), 32'b1110);

    // Random traffic, including mid-frame input changes and resets
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0)
        set_in(16'($urandom), 4'($urandom), 4'($urandom),
               ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0,
               4'($urandom), 2'($urandom_range(0, 3)));
      if ($urandom_range(0, 999) == 0) rst = 1'b0;
      else if (!rst && $urandom_range(0, 1) == 0) rst = 1'b1;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

`default_nettype wire
